adder_self_test: RTL and testbench

ADDER_SELF_TEST -- requirements
Module: adder_self_test

---
 rtl/adder_self_test.sv | 168 ++++++++++++++++
 tb/tb_adder_self_test.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_self_test.sv
// Exhaustive self-test sequencer for a combinational adder: walks every operand
// combination, compares {cout,s} with a+b(+cin), counts mismatches and latches the first.
// Optional carry-in stimulus is enabled by defining ADDER_SELF_TEST_CIN_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_DRIVE | a/b (and cin) freshly loaded from the vector index
// S_WAIT  | SETTLE-cycle settling window; skipped when SETTLE=0
// S_CHECK | compare adder response against expected sum
// S_DONE  | run complete; results held until next start or rst

module adder_self_test #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
`ifdef ADDER_SELF_TEST_CIN_EN
    output logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

`ifdef ADDER_SELF_TEST_CIN_EN
    localparam int CIN_W = 1;
`else
    localparam int CIN_W = 0;
`endif
    localparam int VW = 2 * WIDTH + CIN_W;
    localparam int SW = WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [VW-1:0]    vec;
    logic [CW-1:0]    wait_cnt;
    logic [VW-1:0]    load_vec;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic             cin_bit;
    logic [SW-1:0]    expected;
    logic             mismatch;
    logic             last_vec;
    logic             err_sat;
`ifdef ADDER_SELF_TEST_CIN_EN
    logic             load_cin;
`endif

    // Next vector to present: zero on a fresh start, V+1 when leaving CHECK.
    always_comb begin
        load_vec = (state == S_CHECK) ? vec + VW'(1) : '0;
`ifdef ADDER_SELF_TEST_CIN_EN
        {load_a, load_b, load_cin} = load_vec;
        cin_bit = cin;
`else
        {load_a, load_b} = load_vec;
        cin_bit = 1'b0;
`endif
        expected = {1'b0, a} + {1'b0, b} + SW'(cin_bit);
        mismatch = ({cout, s} != expected);
        last_vec = (vec == '1);
        err_sat  = (err_count == 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            vec       <= '0;
            wait_cnt  <= '0;
            a         <= '0;
            b         <= '0;
`ifdef ADDER_SELF_TEST_CIN_EN
            cin       <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        vec       <= load_vec;
                        a         <= load_a;
                        b         <= load_b;
`ifdef ADDER_SELF_TEST_CIN_EN
                        cin       <= load_cin;
`endif
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                    end
                end
                S_DRIVE: begin
                    if (SETTLE == 0) begin
                        state <= S_CHECK;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (!err_sat) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (err_count == '0) begin
                            fail_a <= a;
                            fail_b <= b;
                        end
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == '0);
                    end else begin
                        state <= S_DRIVE;
                        vec   <= load_vec;
                        a     <= load_a;
                        b     <= load_b;
`ifdef ADDER_SELF_TEST_CIN_EN
                        cin   <= load_cin;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_self_test.sv
// Directed bench for adder_self_test: two instances (1-bit with one settle cycle and a
// second with no settle window) driven against good and faulty adder models.

module tb_adder_self_test;

    localparam int W1 = 1;
    localparam int S1 = 1;
`ifdef ADDER_SELF_TEST_CIN_EN
    localparam int W2   = 1;
    localparam int S2   = 0;
    localparam int RUN1 = 24;
    localparam int RUN2 = 16;
`else
    localparam int W2   = 2;
    localparam int S2   = 0;
    localparam int RUN1 = 12;
    localparam int RUN2 = 32;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start1;
    logic start2;

    logic [W1-1:0] a1, b1, s1, fail_a1, fail_b1;
    logic          cout1, busy1, done1, pass1;
    logic [15:0]   err1;
    logic [W2-1:0] a2, b2, s2, fail_a2, fail_b2;
    logic          cout2, busy2, done2, pass2;
    logic [15:0]   err2;
    logic          cin1, cin2;

    int mode1;
    int mode2;
    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    adder_self_test #(.WIDTH(W1), .SETTLE(S1)) dut (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .s(s1), .cout(cout1),
`ifdef ADDER_SELF_TEST_CIN_EN
        .cin(cin1),
`endif
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fail_a1), .fail_b(fail_b1)
    );

    adder_self_test #(.WIDTH(W2), .SETTLE(S2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a(a2), .b(b2), .s(s2), .cout(cout2),
`ifdef ADDER_SELF_TEST_CIN_EN
        .cin(cin2),
`endif
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_a(fail_a2), .fail_b(fail_b2)
    );

`ifndef ADDER_SELF_TEST_CIN_EN
    assign cin1 = 1'b0;
    assign cin2 = 1'b0;
`endif

    // Adder models: 0 good, 1 s=a|b (dut) / s stuck 0 (dut2), 2 cout stuck 1, 3 ignores cin
    always_comb begin
        {cout1, s1} = {1'b0, a1} + {1'b0, b1} + {{W1{1'b0}}, cin1};
        if (mode1 == 1) s1 = a1 | b1;
        if (mode1 == 2) cout1 = 1'b1;
        if (mode1 == 3) {cout1, s1} = {1'b0, a1} + {1'b0, b1};
        {cout2, s2} = {1'b0, a2} + {1'b0, b2} + {{W2{1'b0}}, cin2};
        if (mode2 == 1) s2 = '0;
        if (mode2 == 2) cout2 = 1'b1;
        if (mode2 == 3) {cout2, s2} = {1'b0, a2} + {1'b0, b2};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles of dut; optionally pulses start or rst at a given busy cycle.
    task automatic run1(output int n, input int restart_at, input int rst_at);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 1000) begin
            n++;
            if (n == restart_at) start1 = 1'b1;
            if (n == rst_at) rst = 1'b1;
            tick();
            start1 = 1'b0;
            if (n == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    task automatic run2(output int n);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (busy2 && n < 1000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode1 = 0; mode2 = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_ab", {a1, b1}, 0);
        chk("rst_fail", {fail_a1, fail_b1}, 0);
        chk("rst_busy2", busy2, 0);

        // good adder on dut
        mode1 = 0;
        run1(cyc, 0, 0);
        chk("good_cycles", cyc, RUN1);
        chk("good_done", done1, 1);
        chk("good_pass", pass1, 1);
        chk("good_err", err1, 0);
        chk("good_last_ab", {a1, b1}, 2'b11);
        tick(); tick(); tick();
        chk("done_hold", done1, 1);
        chk("done_hold_busy", busy1, 0);

`ifndef ADDER_SELF_TEST_CIN_EN
        mode1 = 1;
        run1(cyc, 0, 0);
        chk("or_cycles", cyc, 12);
        chk("or_pass", pass1, 0);
        chk("or_err", err1, 1);
        chk("or_fail_ab", {fail_a1, fail_b1}, 2'b11);

        mode1 = 2;
        run1(cyc, 0, 0);
        chk("cout1_err", err1, 3);
        chk("cout1_fail_ab", {fail_a1, fail_b1}, 2'b00);
        chk("cout1_done", done1, 1);
        chk("cout1_pass", pass1, 0);
`endif

        // second start mid-run must not restart
        mode1 = 0;
        run1(cyc, 5, 0);
        chk("restart_cycles", cyc, RUN1);
        chk("restart_pass", pass1, 1);
        chk("restart_err", err1, 0);

        // reset mid-run with an error already counted
        mode1 = 2;
        run1(cyc, 0, 6);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_err", err1, 0);
        chk("abort_ab", {a1, b1}, 0);
        tick(); tick();
        chk("abort_idle", {busy1, done1, pass1}, 0);
        mode1 = 0;
        run1(cyc, 0, 0);
        chk("after_abort_cycles", cyc, RUN1);
        chk("after_abort_pass", pass1, 1);

        // second instance, no settle window
        mode2 = 0;
        run2(cyc);
        chk("d2_good_cycles", cyc, RUN2);
        chk("d2_good_pass", pass2, 1);
        chk("d2_good_err", err2, 0);
`ifdef ADDER_SELF_TEST_CIN_EN
        chk("d2_last_abc", {a2, b2, cin2}, 3'b111);
        mode2 = 3;
        run2(cyc);
        chk("d2_nocin_cycles", cyc, 16);
        chk("d2_nocin_err", err2, 4);
        chk("d2_nocin_fail_ab", {fail_a2, fail_b2}, 2'b00);
        chk("d2_nocin_pass", pass2, 0);
`else
        chk("d2_last_ab", {a2, b2}, 4'b1111);
        mode2 = 1;
        run2(cyc);
        chk("d2_s0_cycles", cyc, 32);
        chk("d2_s0_err", err2, 12);
        chk("d2_s0_fail_a", fail_a2, 0);
        chk("d2_s0_fail_b", fail_b2, 1);
        chk("d2_s0_pass", pass2, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
